main_mem_responder: RTL and testbench
=====================================

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of the number of MEM_DATA_BITS-wide storage beats.
REQ-002 SHALL have parameter LATENCY, default 4, the number of cycles from read accept to the first response beat (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port mem_req_valid, input, 1, request command valid.
REQ-006 SHALL have port mem_req_ready, output, 1, request command ready.
REQ-007 SHALL have port mem_req_rw, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port mem_req_addr, input, `MEM_ADDR_BITS, beat address; low 2 bits are ignored (block-aligned).
REQ-009 SHALL have port mem_req_tag, input, `MEM_TAG_BITS, request tag.
REQ-010 SHALL have port mem_req_data_valid, input, 1, write data beat valid.
REQ-011 SHALL have port mem_req_data_ready, output, 1, write data beat ready.
REQ-012 SHALL have port mem_req_data_bits, input, `MEM_DATA_BITS, write data beat.
REQ-013 SHALL have port mem_req_data_mask, input, `MEM_DATA_BITS/8, byte-enable mask; bit i enables byte i.
REQ-014 SHALL have port mem_resp_valid, output, 1, read response beat valid; there is no backpressure.
REQ-015 SHALL have port mem_resp_data, output, `MEM_DATA_BITS, read response beat.
REQ-016 SHALL have port mem_resp_tag, output, `MEM_TAG_BITS, tag of the accepted read.

Function
REQ-017 SHALL implement the states IDLE, WDATA, RLAT and RRESP, with one request outstanding at most.
REQ-018 SHALL drive mem_req_ready=1 only in IDLE; a request is accepted when mem_req_valid && mem_req_ready, latching addr[.:2], tag and rw.
REQ-019 SHALL, on an accepted write, go to WDATA, drive mem_req_data_ready=1, write each data beat at {line,beat} under the byte mask, advance beat 0..3 on every handshake, and return to IDLE after beat 3.
REQ-020 SHALL hold mem_req_data_ready=0 outside WDATA and ignore mem_req_data_valid there.
REQ-021 SHALL NOT produce any response for a write.
REQ-022 SHALL, on an accepted read accepted in cycle T, assert mem_resp_valid in cycles T+LATENCY .. T+LATENCY+3 (beats 0..3 in order), with mem_resp_tag constant at the latched tag.
REQ-023 SHALL return to IDLE after the last read beat, with mem_req_ready=1 in cycle T+LATENCY+4.
REQ-024 SHALL drive mem_resp_valid=0 and hold mem_resp_data/mem_resp_tag at their last value outside RRESP.
REQ-025 SHALL wrap addresses modulo 2^DEPTH_LOG2 beats; upper address bits are ignored, with no error.
REQ-026 SHALL return the newly written data for a read that follows a completed write to the same block.
REQ-027 SHALL write nothing for a write beat with mask 0, while still consuming the beat.
REQ-028 SHALL keep the request-accept (command) handshake independent of data-beat (mem_req_data_valid) arrival; data beats presented during IDLE are not accepted.

Reset
REQ-029 SHALL, when reset_n=0, immediately force state to IDLE, beat and latency counters to 0, mem_resp_valid=0, mem_req_data_ready=0, mem_resp_data=0 and mem_resp_tag=0.
REQ-030 SHALL drive mem_req_ready=1 from the first clock edge after reset deasserts.
REQ-031 SHALL, on reset mid-operation, drop a pending read response and abandon a partial write (beats already written remain written).
REQ-032 SHALL NOT reset storage contents.

Structure
REQ-033 SHALL take MEM_ADDR_BITS, MEM_DATA_BITS, MEM_TAG_BITS and MEM_DATA_CYCLES (=4) from the shared const.vh; the state encoding stays local.
REQ-034 SHALL place storage in one sub-module, main_mem_sram: a single-port, byte-masked, synchronous-read array of depth 2^DEPTH_LOG2; the read is issued so that data is ready at the beat's cycle.

Verification
REQ-035 SHALL cover: write addr 0x40, tag 3, beats 0x11..,0x22..,0x33..,0x44.., mask all-ones; then read addr 0x40, tag 7 -> 4 beats in order, tag 7, first beat exactly LATENCY cycles after accept.
REQ-036 SHALL cover: write mask 0x0001 with data 0xFF to a block previously holding 0 -> read returns byte0=0xFF and all other bytes 0.
REQ-037 SHALL cover: write data beats with 2-cycle gaps in data_valid -> mem_req_ready stays 0 until after beat 3, and all 4 beats are stored correctly.
REQ-038 SHALL cover: mem_req_valid held high continuously during a read -> second accept occurs in cycle T+LATENCY+4, never earlier.
REQ-039 SHALL cover: addr 0x40 + 2^DEPTH_LOG2 aliases to 0x40, and addr 0x43 is treated as 0x40.
REQ-040 SHALL cover: reset_n pulsed low in cycle T+1 of a read -> no mem_resp_valid, and mem_req_ready=1 after release.

Source files
------------

// File: rtl/main_mem_responder_pkg.sv
// main_mem_responder_pkg
//   Shared memory-interface widths and helpers for the main-memory responder
//   and its storage array. The FSM state encoding is deliberately kept local
//   to the top module.
package main_mem_responder_pkg;

  localparam int MEM_ADDR_BITS   = 26;
  localparam int MEM_DATA_BITS   = 128;
  localparam int MEM_TAG_BITS    = 5;
  localparam int MEM_DATA_CYCLES = 4;
  localparam int MEM_MASK_BITS   = MEM_DATA_BITS / 8;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_rw_e;

  // Byte-enable mask to per-bit write mask.
  function automatic logic [MEM_DATA_BITS-1:0] expand_mask(
    input logic [MEM_MASK_BITS-1:0] m
  );
    logic [MEM_DATA_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < MEM_MASK_BITS; i++) begin
      r[i*8 +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/main_mem_responder_sram.sv
// main_mem_sram
//   Single-port, byte-masked, synchronous-read storage array.
//   Ports:
//     clk_i    - clock
//     rst_ni   - async active-low reset (read register only; contents are
//                never cleared)
//     en_i     - access enable
//     we_i     - 1 = write, 0 = read (when en_i)
//     addr_i   - beat index
//     wdata_i  - write data
//     wmask_i  - byte enables for writes
//     rdata_o  - read data, valid the cycle after a read access and held
//                until the next read
module main_mem_sram
  import main_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [DEPTH_LOG2-1:0]    addr_i,
  input  logic [MEM_DATA_BITS-1:0] wdata_i,
  input  logic [MEM_MASK_BITS-1:0] wmask_i,
  output logic [MEM_DATA_BITS-1:0] rdata_o
);

  logic [MEM_DATA_BITS-1:0] mem_q [2**DEPTH_LOG2];
  logic [MEM_DATA_BITS-1:0] rdata_q;
  logic [MEM_DATA_BITS-1:0] bit_mask;

  assign bit_mask = expand_mask(wmask_i);

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= (mem_q[addr_i] & ~bit_mask) | (wdata_i & bit_mask);
    end
  end

  // Only reads update the output register, so the last response beat stays
  // visible across writes and idle cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder
//   Simple main-memory model: accepts one block request at a time, stores
//   4-beat write blocks under a byte mask and returns 4-beat read blocks a
//   fixed LATENCY cycles after accept.
//   Ports:
//     clk, reset_n                - clock, async active-low reset
//     mem_req_valid/ready         - command handshake (ready only in IDLE)
//     mem_req_rw/addr/tag         - command fields (addr low 2 bits ignored)
//     mem_req_data_valid/ready    - write data beat handshake (WDATA only)
//     mem_req_data_bits/mask      - write beat and byte enables
//     mem_resp_valid/data/tag     - read response beats, no backpressure
//
//   state | meaning
//   IDLE  | ready for a command
//   WDATA | collecting 4 write beats
//   RLAT  | counting down read latency
//   RRESP | driving 4 read beats
module main_mem_responder
  import main_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mem_req_valid,
  output logic                     mem_req_ready,
  input  logic                     mem_req_rw,
  input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  input  logic [MEM_TAG_BITS-1:0]  mem_req_tag,
  input  logic                     mem_req_data_valid,
  output logic                     mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
  output logic                     mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0] mem_resp_data,
  output logic [MEM_TAG_BITS-1:0]  mem_resp_tag
);

  localparam int LINE_BITS = DEPTH_LOG2 - 2;
  localparam logic [1:0] LAST_BEAT = 2'(MEM_DATA_CYCLES - 1);
  // RLAT lasts LATENCY-1 cycles; the read of beat 0 is issued in its last one.
  localparam logic [3:0] LAT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RLAT  = 2'd2,
    RRESP = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [LINE_BITS-1:0]    line_q, line_d;
  logic [1:0]              beat_q, beat_d;
  logic [3:0]              lat_q, lat_d;
  logic [MEM_TAG_BITS-1:0] tag_q, tag_d;
  logic [MEM_TAG_BITS-1:0] resp_tag_q;
  logic                    req_ready_q;
  logic                    data_ready_q;
  logic                    resp_valid_q;

  logic                    accept;
  logic                    sram_en;
  logic                    sram_we;
  logic [DEPTH_LOG2-1:0]   sram_addr;
  logic [MEM_DATA_BITS-1:0] sram_rdata;

  // Upper address bits wrap silently; the low 2 bits select nothing.
  logic unused_addr;
  assign unused_addr = ^{mem_req_addr[MEM_ADDR_BITS-1:LINE_BITS+2],
                         mem_req_addr[1:0]};

  assign accept = mem_req_valid && req_ready_q;

  // Next-state and SRAM access. Reads are issued one cycle ahead of the beat
  // that presents them, since the array has a registered read port.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    tag_d     = tag_q;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = {line_q, beat_q};
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          line_d = mem_req_addr[LINE_BITS+1:2];
          tag_d  = mem_req_tag;
          beat_d = 2'd0;
          if (mem_req_rw == MEM_WRITE) begin
            state_d = WDATA;
          end else if (LATENCY == 1) begin
            state_d   = RRESP;
            sram_en   = 1'b1;
            sram_addr = {line_d, 2'd0};
          end else begin
            state_d = RLAT;
            lat_d   = LAT_INIT;
          end
        end
      end
      WDATA: begin
        if (mem_req_data_valid) begin
          sram_en = 1'b1;
          sram_we = 1'b1;
          beat_d  = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end
      RLAT: begin
        if (lat_q == 4'd0) begin
          state_d = RRESP;
          sram_en = 1'b1;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RRESP: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
        end else begin
          sram_en   = 1'b1;
          sram_addr = {line_q, beat_d};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      line_q       <= '0;
      beat_q       <= '0;
      lat_q        <= '0;
      tag_q        <= '0;
      resp_tag_q   <= '0;
      req_ready_q  <= 1'b0;
      data_ready_q <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      beat_q       <= beat_d;
      lat_q        <= lat_d;
      tag_q        <= tag_d;
      req_ready_q  <= (state_d == IDLE);
      data_ready_q <= (state_d == WDATA);
      resp_valid_q <= (state_d == RRESP);
      // Response tag only moves when a read burst starts, so it holds
      // through writes and idle time.
      if (state_d == RRESP && state_q != RRESP) begin
        resp_tag_q <= tag_d;
      end
    end
  end

  main_mem_sram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .en_i    (sram_en),
    .we_i    (sram_we),
    .addr_i  (sram_addr),
    .wdata_i (mem_req_data_bits),
    .wmask_i (mem_req_data_mask),
    .rdata_o (sram_rdata)
  );

  assign mem_req_ready      = req_ready_q;
  assign mem_req_data_ready = data_ready_q;
  assign mem_resp_valid     = resp_valid_q;
  assign mem_resp_data      = sram_rdata;
  assign mem_resp_tag       = resp_tag_q;

endmodule

// File: tb/tb_main_mem_responder.sv
module tb_main_mem_responder;
  import main_mem_responder_pkg::*;

  localparam int DEPTH_LOG2 = 10;
  localparam int LAT        = 4;

  typedef struct {
    logic [MEM_DATA_BITS-1:0] data;
    logic [MEM_TAG_BITS-1:0]  tag;
    int                       cyc;
  } exp_t;

  logic                     clk;
  logic                     reset_n;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_rw;
  logic [MEM_ADDR_BITS-1:0] mem_req_addr;
  logic [MEM_TAG_BITS-1:0]  mem_req_tag;
  logic                     mem_req_data_valid;
  logic                     mem_req_data_ready;
  logic [MEM_DATA_BITS-1:0] mem_req_data_bits;
  logic [MEM_MASK_BITS-1:0] mem_req_data_mask;
  logic                     mem_resp_valid;
  logic [MEM_DATA_BITS-1:0] mem_resp_data;
  logic [MEM_TAG_BITS-1:0]  mem_resp_tag;

  int   cyc;
  int   n_total;
  int   n_pass;
  exp_t exp_q[$];

  main_mem_responder #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .LATENCY   (LAT)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_rw        (mem_req_rw),
    .mem_req_addr      (mem_req_addr),
    .mem_req_tag       (mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits (mem_req_data_bits),
    .mem_req_data_mask (mem_req_data_mask),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data),
    .mem_resp_tag      (mem_resp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor: pops one expected beat per observed response beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 128'(mem_resp_valid), 128'(1'b0));
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", mem_resp_data, e.data);
          chk("resp_tag", 128'(mem_resp_tag), 128'(e.tag));
          chk("resp_cycle", 128'(cyc), 128'(e.cyc));
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_resp", 128'(mem_resp_valid), 128'(1'b1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // Called just after a negedge; returns at the negedge after the accept.
  task automatic issue(input logic rw, input logic [MEM_ADDR_BITS-1:0] addr,
                       input logic [MEM_TAG_BITS-1:0] tag, output int t_acc);
    int n;
    mem_req_valid = 1'b1;
    mem_req_rw    = rw;
    mem_req_addr  = addr;
    mem_req_tag   = tag;
    n = 0;
    while (!mem_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 128'(mem_req_ready), 128'(1'b1));
    t_acc = cyc;
    @(negedge clk);
    mem_req_valid = 1'b0;
  endtask

  task automatic write_block(input logic [MEM_ADDR_BITS-1:0] addr, input logic [MEM_TAG_BITS-1:0] tag,
                             input logic [127:0] d0, input logic [127:0] d1,
                             input logic [127:0] d2, input logic [127:0] d3,
                             input logic [15:0] mask, input int gap);
    int t;
    logic [127:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    issue(1'b1, addr, tag, t);
    for (int b = 0; b < 4; b++) begin
      mem_req_data_valid = 1'b1;
      mem_req_data_bits  = d[b];
      mem_req_data_mask  = mask;
      chk("wdata_ready", 128'(mem_req_data_ready), 128'(1'b1));
      @(negedge clk);
      mem_req_data_valid = 1'b0;
      if (b < 3) begin
        chk("ready_in_write", 128'(mem_req_ready), 128'(1'b0));
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("ready_in_gap", 128'(mem_req_ready), 128'(1'b0));
        end
      end
    end
    chk("ready_after_write", 128'(mem_req_ready), 128'(1'b1));
    chk("dready_after_write", 128'(mem_req_data_ready), 128'(1'b0));
  endtask

  task automatic push_read(input int t, input logic [MEM_TAG_BITS-1:0] tag,
                           input logic [127:0] d0, input logic [127:0] d1,
                           input logic [127:0] d2, input logic [127:0] d3);
    exp_t e;
    e.tag = tag;
    e.data = d0; e.cyc = t + LAT;     exp_q.push_back(e);
    e.data = d1; e.cyc = t + LAT + 1; exp_q.push_back(e);
    e.data = d2; e.cyc = t + LAT + 2; exp_q.push_back(e);
    e.data = d3; e.cyc = t + LAT + 3; exp_q.push_back(e);
  endtask

  task automatic read_block(input logic [MEM_ADDR_BITS-1:0] addr, input logic [MEM_TAG_BITS-1:0] tag,
                            input logic [127:0] d0, input logic [127:0] d1,
                            input logic [127:0] d2, input logic [127:0] d3);
    int t;
    issue(1'b0, addr, tag, t);
    push_read(t, tag, d0, d1, d2, d3);
    while (cyc < t + LAT + 3) @(negedge clk);
    chk("ready_last_beat", 128'(mem_req_ready), 128'(1'b0));
    @(negedge clk);
    chk("ready_after_read", 128'(mem_req_ready), 128'(1'b1));
    chk("tag_hold", 128'(mem_resp_tag), 128'(tag));
    chk("data_hold", mem_resp_data, d3);
  endtask

  localparam logic [127:0] D11 = {16{8'h11}};
  localparam logic [127:0] D22 = {16{8'h22}};
  localparam logic [127:0] D33 = {16{8'h33}};
  localparam logic [127:0] D44 = {16{8'h44}};
  localparam logic [127:0] DA1 = {16{8'hA1}};
  localparam logic [127:0] DA2 = {16{8'hA2}};
  localparam logic [127:0] DA3 = {16{8'hA3}};
  localparam logic [127:0] DA4 = {16{8'hA4}};
  localparam logic [127:0] DFF = {16{8'hFF}};
  localparam logic [127:0] DEE = {16{8'hEE}};
  localparam logic [127:0] B0FF = 128'h0000_0000_0000_0000_0000_0000_0000_00FF;

  initial begin
    int t1, t2, n;
    n_total = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rw = 1'b0;
    mem_req_addr = '0;
    mem_req_tag = '0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits = '0;
    mem_req_data_mask = '0;

    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 128'(mem_resp_valid), 128'(1'b0));
    chk("rst_data_ready", 128'(mem_req_data_ready), 128'(1'b0));
    chk("rst_resp_data", mem_resp_data, 128'h0);
    chk("rst_resp_tag", 128'(mem_resp_tag), 128'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 128'(mem_req_ready), 128'(1'b1));

    // Basic write then read of block 0x40.
    write_block(26'h40, 5'd3, D11, D22, D33, D44, 16'hFFFF, 0);
    read_block(26'h40, 5'd7, D11, D22, D33, D44);

    // Single-byte mask into a zeroed block.
    write_block(26'h80, 5'd1, '0, '0, '0, '0, 16'hFFFF, 0);
    write_block(26'h80, 5'd2, DFF, DFF, DFF, DFF, 16'h0001, 0);
    read_block(26'h80, 5'd6, B0FF, B0FF, B0FF, B0FF);

    // Write beats with 2-cycle gaps.
    write_block(26'hC0, 5'd8, DA1, DA2, DA3, DA4, 16'hFFFF, 2);
    read_block(26'hC0, 5'd9, DA1, DA2, DA3, DA4);

    // Mask-0 write leaves the block untouched; stray data beats in IDLE ignored.
    write_block(26'h40, 5'd10, DEE, DEE, DEE, DEE, 16'h0000, 0);
    mem_req_data_valid = 1'b1;
    mem_req_data_bits  = DEE;
    mem_req_data_mask  = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      chk("idle_data_ready", 128'(mem_req_data_ready), 128'(1'b0));
      @(negedge clk);
    end
    mem_req_data_valid = 1'b0;

    // Address aliasing: wrap above depth, low 2 bits ignored.
    read_block(26'h40 + 26'(2**DEPTH_LOG2), 5'd1, D11, D22, D33, D44);
    read_block(26'h43, 5'd2, D11, D22, D33, D44);

    // mem_req_valid held continuously across a read.
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 26'hC0;
    mem_req_tag   = 5'd4;
    n = 0;
    while (!mem_req_ready && n < 50) begin @(negedge clk); n++; end
    t1 = cyc;
    push_read(t1, 5'd4, DA1, DA2, DA3, DA4);
    @(negedge clk);
    mem_req_addr = 26'h80;
    mem_req_tag  = 5'd5;
    n = 0;
    while (!mem_req_ready && n < 50) begin @(negedge clk); n++; end
    t2 = cyc;
    chk("b2b_accept_cycle", 128'(t2), 128'(t1 + LAT + 4));
    push_read(t2, 5'd5, B0FF, B0FF, B0FF, B0FF);
    @(negedge clk);
    mem_req_valid = 1'b0;
    while (cyc < t2 + LAT + 4) @(negedge clk);

    // Reset during read latency: response dropped.
    issue(1'b0, 26'h40, 5'd12, t1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_resp_valid", 128'(mem_resp_valid), 128'(1'b0));
    chk("midrst_resp_tag", 128'(mem_resp_tag), 128'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 128'(mem_req_ready), 128'(1'b1));
    repeat (LAT + 6) @(negedge clk);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain_empty", 128'(exp_q.size()), 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
